// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch unit, the instruction memory and the decode stage.
// The master modport is the fetch unit itself; the slave modport is its environment.
interface instruction_fetch_unit_if #(
   parameter int XLEN = 32,
   parameter int ILEN = 32
);
   logic            mem_ren;
   logic [XLEN-1:0] mem_addr;
   logic [XLEN-1:0] mem_rdata;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            instr_valid;
   logic            instr_ready;
   logic [ILEN-1:0] instr_bits;
   logic [XLEN-1:0] instr_pc;
   logic            fetch_fault;
   logic [XLEN-1:0] fault_pc;

   modport master (
      output mem_ren, mem_addr, instr_valid, instr_bits, instr_pc, fetch_fault, fault_pc,
      input  mem_rdata, redirect_valid, redirect_pc, instr_ready
   );

   modport slave (
      input  mem_ren, mem_addr, instr_valid, instr_bits, instr_pc, fetch_fault, fault_pc,
      output mem_rdata, redirect_valid, redirect_pc, instr_ready
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Front-end fetch stage: sequences the PC, issues 1-cycle-latency word reads and
// buffers returned words in a small FIFO toward decode; handles redirects and faults.
module instruction_fetch_unit #(
   parameter int              XLEN       = 32,
   parameter int              ILEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
   parameter int              FIFO_DEPTH = 4
) (
   input logic                     clock,
   input logic                     reset,
   instruction_fetch_unit_if.master bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [0:0] ST_FETCH = 1'b0;
   localparam logic [0:0] ST_FAULT = 1'b1;

   logic [0:0]      state_r;
   logic [XLEN-1:0] fetch_pc_r;
   logic [XLEN-1:0] inflight_pc_r;
   logic [XLEN-1:0] fault_pc_r;
   logic            inflight_r;
   logic [CNT_W-1:0] count_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [ILEN-1:0] bits_mem_r [FIFO_DEPTH];
   logic [XLEN-1:0] pc_mem_r   [FIFO_DEPTH];

   logic            issue_s;
   logic            valid_s;
   logic            push_s;
   logic            pop_s;
   logic            aligned_s;
   logic [CNT_W:0]  pending_s;

   // Issue/valid decisions; mem_ren never depends on instr_ready.
   always_comb begin
      pending_s = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r};
      aligned_s = (bus.redirect_pc[1:0] == 2'b00);
      if (!reset && (state_r == ST_FETCH) && !bus.redirect_valid) begin
         issue_s = (pending_s < (CNT_W + 1)'(FIFO_DEPTH));
         valid_s = (count_r != {CNT_W{1'b0}});
      end else begin
         issue_s = 1'b0;
         valid_s = 1'b0;
      end
      // A response arriving in a redirect cycle is dropped along with the flush.
      push_s = inflight_r && !bus.redirect_valid && !reset;
      pop_s  = valid_s && bus.instr_ready;
   end

   // Control state: PC sequencing, in-flight tracking, FIFO pointers and fault capture.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r       <= ST_FETCH;
         fetch_pc_r    <= RESET_PC;
         inflight_pc_r <= RESET_PC;
         inflight_r    <= 1'b0;
         count_r       <= {CNT_W{1'b0}};
         wr_ptr_r      <= {PTR_W{1'b0}};
         rd_ptr_r      <= {PTR_W{1'b0}};
         fault_pc_r    <= {XLEN{1'b0}};
      end else if (bus.redirect_valid) begin
         inflight_r <= 1'b0;
         count_r    <= {CNT_W{1'b0}};
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         if (aligned_s) begin
            state_r    <= ST_FETCH;
            fetch_pc_r <= bus.redirect_pc;
         end else begin
            state_r    <= ST_FAULT;
            fault_pc_r <= bus.redirect_pc;
         end
      end else begin
         inflight_r <= issue_s;
         if (issue_s) begin
            fetch_pc_r    <= fetch_pc_r + XLEN'(32'd4);
            inflight_pc_r <= fetch_pc_r;
         end
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1'b1);
            2'b01:   count_r <= count_r - CNT_W'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Instruction buffer storage; contents are only meaningful below count_r.
   always_ff @(posedge clock) begin
      if (push_s) begin
         bits_mem_r[wr_ptr_r] <= bus.mem_rdata[ILEN-1:0];
         pc_mem_r[wr_ptr_r]   <= inflight_pc_r;
      end
   end

   assign bus.mem_ren     = issue_s;
   assign bus.mem_addr    = fetch_pc_r;
   assign bus.instr_valid = valid_s;
   assign bus.instr_bits  = bits_mem_r[rd_ptr_r];
   assign bus.instr_pc    = pc_mem_r[rd_ptr_r];
   assign bus.fetch_fault = (state_r == ST_FAULT);
   assign bus.fault_pc    = fault_pc_r;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a cycle model predicts issue,
// delivery and fault behaviour, and checks the DUT every cycle on the falling edge.
module tb_instruction_fetch_unit;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clock = 1'b0;
   logic reset;

   instruction_fetch_unit_if #(.XLEN(32), .ILEN(32)) ifc ();

   instruction_fetch_unit #(
      .XLEN(32), .ILEN(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (ifc.master)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] bits;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_xfer   = 0;
   int          cyc      = 0;
   logic [31:0] exp_issue = RESET_PC;
   logic        m_fault   = 1'b0;
   logic [31:0] m_fault_pc = 32'h0000_0000;
   logic        req_v = 1'b0;
   logic [31:0] req_addr = 32'h0000_0000;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: mem_word = 32'h0050_0793;
         32'h0000_0004: mem_word = 32'h0017_8793;
         32'h0000_0008: mem_word = 32'hFFF7_8793;
         default:       mem_word = a ^ 32'h1357_9BDF;
      endcase
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", tag, cyc, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Memory model: capture the request away from the edge, answer one cycle later.
   always @(negedge clock) begin
      req_v    = ifc.mem_ren;
      req_addr = ifc.mem_addr;
   end

   always @(posedge clock) begin
      ifc.mem_rdata <= req_v ? mem_word(req_addr) : 32'hDEAD_BEEF;
   end

   // Reference model and scoreboard.
   always @(negedge clock) begin
      logic exp_ren;
      logic exp_val;
      cyc++;
      if (reset) begin
         check_eq("rst_mem_ren", {31'd0, ifc.mem_ren}, 32'd0);
         check_eq("rst_instr_valid", {31'd0, ifc.instr_valid}, 32'd0);
         exp_q.delete();
         exp_issue  = RESET_PC;
         m_fault    = 1'b0;
         m_fault_pc = 32'h0000_0000;
      end else begin
         exp_ren = !m_fault && !ifc.redirect_valid && (exp_q.size() < DEPTH);
         exp_val = !m_fault && !ifc.redirect_valid && (exp_q.size() > 0);
         if (exp_val) exp_val = (cyc - exp_q[0].cyc) >= 2;
         check_eq("fetch_fault", {31'd0, ifc.fetch_fault}, {31'd0, m_fault});
         check_eq("fault_pc", ifc.fault_pc, m_fault_pc);
         check_eq("mem_ren", {31'd0, ifc.mem_ren}, {31'd0, exp_ren});
         check_eq("instr_valid", {31'd0, ifc.instr_valid}, {31'd0, exp_val});
         if (ifc.instr_valid && exp_val) begin
            check_eq("instr_pc", ifc.instr_pc, exp_q[0].pc);
            check_eq("instr_bits", ifc.instr_bits, exp_q[0].bits);
         end
         if (ifc.redirect_valid) begin
            exp_q.delete();
            if (ifc.redirect_pc[1:0] == 2'b00) begin
               exp_issue = ifc.redirect_pc;
               m_fault   = 1'b0;
            end else begin
               m_fault    = 1'b1;
               m_fault_pc = ifc.redirect_pc;
            end
         end else begin
            if (ifc.instr_valid && exp_val && ifc.instr_ready) begin
               void'(exp_q.pop_front());
               n_xfer++;
            end
            if (ifc.mem_ren && exp_ren) begin
               check_eq("mem_addr", ifc.mem_addr, exp_issue);
               exp_q.push_back('{pc: exp_issue, bits: mem_word(exp_issue), cyc: cyc});
               exp_issue = exp_issue + 32'd4;
            end
         end
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      ifc.redirect_valid = 1'b1;
      ifc.redirect_pc    = pc;
      tick(1);
      ifc.redirect_valid = 1'b0;
   endtask

   initial begin
      int waited;
      reset              = 1'b1;
      ifc.redirect_valid = 1'b0;
      ifc.redirect_pc    = 32'h0000_0000;
      ifc.instr_ready    = 1'b1;
      tick(3);

      // Streaming with decode always ready.
      reset = 1'b0;
      tick(12);

      // Back-pressure: FIFO fills, then drains in order.
      reset = 1'b1; ifc.instr_ready = 1'b0;
      tick(1);
      reset = 1'b0;
      tick(10);
      ifc.instr_ready = 1'b1;
      tick(10);

      // Redirect with 0x8 in flight and 0,4 buffered.
      reset = 1'b1; ifc.instr_ready = 1'b0;
      tick(1);
      reset = 1'b0;
      tick(3);
      do_redirect(32'h0000_0060);
      ifc.instr_ready = 1'b1;
      tick(6);

      // Misaligned targets, then recovery.
      do_redirect(32'h0000_0062);
      tick(4);
      do_redirect(32'h0000_0067);
      tick(3);
      do_redirect(32'h0000_0040);
      tick(6);

      // Address wrap and back-to-back redirects.
      do_redirect(32'hFFFF_FFFC);
      tick(6);
      ifc.redirect_valid = 1'b1; ifc.redirect_pc = 32'h0000_0100;
      tick(1);
      ifc.redirect_pc = 32'h0000_0200;
      tick(1);
      ifc.redirect_valid = 1'b0;
      tick(6);

      // Reset mid-stream once fetch_pc reaches 0x20.
      do_redirect(32'h0000_0000);
      waited = 0;
      while (exp_issue != 32'h0000_0020 && waited < 50) begin
         tick(1);
         waited++;
      end
      check_eq("reach_0x20_timeout", {31'd0, (waited < 50)}, 32'd1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(6);

      // Random ready and redirect traffic.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] tgt;
         ifc.instr_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) begin
            tgt = $urandom & 32'h0000_03FC;
            if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            ifc.redirect_valid = 1'b1;
            ifc.redirect_pc    = tgt;
         end else begin
            ifc.redirect_valid = 1'b0;
         end
         tick(1);
      end
      ifc.redirect_valid = 1'b0;
      tick(2);

      check_eq("enough_transfers", {31'd0, (n_xfer > 100)}, 32'd1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
